// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce block.
//   state_e   : debounce FSM state (2-bit encoding)
//   width_of  : bits needed to hold the values 0..n-1 (never less than 1)
//   max_of    : larger of two unsigned values
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    DISARMING = 2'd3
  } state_e;

  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, both flops clear to 0
//   d       : asynchronous input
//   q       : synchronized output, two clock edges behind d
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      s1_q <= d;
      s_q  <= s1_q;
    end
  end

  assign q = s_q;

endmodule

// File: rtl/debounce.sv
// Debouncer with optional hold-to-repeat, feeding the one-shot pulse stretcher.
//   clk         : sole clock, rising edge
//   reset_n     : asynchronous active-low reset
//   raw_in      : asynchronous bouncy active-high button
//   level       : debounced level
//   press       : one-cycle pulse on accepted 0->1
//   release_evt : one-cycle pulse on accepted 1->0 ("release" is a reserved word)
//   rpt         : one-cycle repeat pulse while held (disabled when REPEAT_DELAY = 0)
//   trig        : press | rpt delayed by one cycle; drives the one-shot input
module debounce
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY  = 0,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic level,
  output logic press,
  output logic release_evt,
  output logic rpt,
  output logic trig
);

  localparam int unsigned CW = width_of(STABLE_CYCLES);
  localparam int unsigned RW = width_of(max_of(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  localparam logic [CW-1:0] CntLast   = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CntOne    = CW'(1);
  localparam logic [RW-1:0] RptDelay  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RptPeriod = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] RptOne    = RW'(1);

  logic s;

  sync2 u_sync2 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (raw_in),
    .q       (s)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          rpt_q, rpt_d;
  logic          trig_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;

    unique case (state_q)
      RELEASED: begin
        level_d = 1'b0;
        if (s) begin
          state_d = ARMING;
          cnt_d   = CntOne;
        end
      end

      ARMING: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
          rcnt_d  = RptDelay;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      PRESSED: begin
        level_d = 1'b1;
        // rcnt stays at 0 forever when repeat is disabled, so rpt never fires.
        // Not reachable in the press cycle itself, which keeps rpt and press disjoint.
        if (rcnt_q == RptOne) begin
          rpt_d  = 1'b1;
          rcnt_d = RptPeriod;
        end else if (rcnt_q != '0) begin
          rcnt_d = rcnt_q - RptOne;
        end
        if (!s) begin
          state_d = DISARMING;
          cnt_d   = CntOne;
        end
      end

      DISARMING: begin
        // Repeat counter is frozen here so a short release glitch resumes the cadence.
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = RELEASED;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
          rcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
        rcnt_d  = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
      trig_q  <= press_q | rpt_q;
    end
  end

  assign level       = level_q;
  assign press       = press_q;
  assign release_evt = rel_q;
  assign rpt         = rpt_q;
  assign trig        = trig_q;

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce: STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 on the
// main instance, plus a REPEAT_DELAY=0 instance sharing the same stimulus.
module tb_debounce;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic raw_in = 1'b0;

  logic level, press, rel, rpt, trig;
  logic level2, press2, rel2, rpt2, trig2;

  int total = 0;
  int bad = 0;
  int e = -1;

  always #5 clk = ~clk;

  debounce #(
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .raw_in      (raw_in),
    .level       (level),
    .press       (press),
    .release_evt (rel),
    .rpt         (rpt),
    .trig        (trig)
  );

  debounce #(
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (0),
    .REPEAT_PERIOD (3)
  ) u_dut_norpt (
    .clk         (clk),
    .reset_n     (reset_n),
    .raw_in      (raw_in),
    .level       (level2),
    .press       (press2),
    .release_evt (rel2),
    .rpt         (rpt2),
    .trig        (trig2)
  );

  // Advance one rising edge; e is the index of the edge just taken.
  task automatic tick();
    @(posedge clk);
    e = e + 1;
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s (edge %0d): observed=%0d expected=%0d", tag, e, obs, exp);
    end
  endtask

  initial begin
    int npress2, nrpt2, ntrig2, nrpt, nrel;
    logic [3:0] bounce_pat;
    logic [10:0] rel_pat;

    // Reset state
    #12;
    chk("rst_level", level, 0);
    chk("rst_press", press, 0);
    chk("rst_release", rel, 0);
    chk("rst_rpt", rpt, 0);
    chk("rst_trig", trig, 0);
    chk("rst_level2", level2, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Bounce rejection: 1,0,1,0 then steady 0
    bounce_pat = 4'b0101;
    e = -1;
    for (int i = 0; i < 12; i++) begin
      raw_in = (i < 4) ? bounce_pat[i] : 1'b0;
      tick();
      chk("bounce_level", level, 0);
      chk("bounce_press", press, 0);
      chk("bounce_trig", trig, 0);
    end

    // Clean press at edge 0 and hold: press at 5, trig at 6, rpt at 15/18/21/24
    raw_in = 1'b1;
    e = -1;
    while (e < 25) begin
      tick();
      chk("hold_level", level, (e >= 5) ? 1 : 0);
      chk("hold_press", press, (e == 5) ? 1 : 0);
      chk("hold_rpt", rpt, (e == 15 || e == 18 || e == 21 || e == 24) ? 1 : 0);
      chk("hold_trig", trig, (e == 6 || e == 16 || e == 19 || e == 22 || e == 25) ? 1 : 0);
      chk("hold_release", rel, 0);
    end

    // Release with a 2-cycle glitch back high: samples 0,1,1,0,0,... -> release at edge 8
    rel_pat = 11'b000_0000_0110;
    e = -1;
    nrel = 0;
    for (int i = 0; i < 11; i++) begin
      raw_in = rel_pat[i];
      tick();
      nrel = nrel + (rel ? 1 : 0);
      chk("rel_release", rel, (e == 8) ? 1 : 0);
      chk("rel_level", level, (e < 8) ? 1 : 0);
      chk("rel_press", press, 0);
    end
    chk("rel_count", nrel, 1);

    // Reset while ARMING with cnt=2
    raw_in = 1'b1;
    e = -1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arm_level", level, 0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_press", press, 0);
    chk("mid_rst_release", rel, 0);
    chk("mid_rst_rpt", rpt, 0);
    chk("mid_rst_trig", trig, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("in_rst_level", level, 0);
      chk("in_rst_press", press, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    e = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_press", press, (e == 5) ? 1 : 0);
      chk("post_rst_level", level, (e >= 5) ? 1 : 0);
      chk("post_rst_trig", trig, (e == 6) ? 1 : 0);
    end

    // Let both instances release cleanly
    raw_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("settle_level", level, 0);
    chk("settle_level2", level2, 0);

    // Long hold: no-repeat instance gives one press and no rpt; main gives 14 rpts
    raw_in = 1'b1;
    e = -1;
    npress2 = 0;
    nrpt2 = 0;
    ntrig2 = 0;
    nrpt = 0;
    for (int i = 0; i < 56; i++) begin
      tick();
      npress2 = npress2 + (press2 ? 1 : 0);
      nrpt2   = nrpt2 + (rpt2 ? 1 : 0);
      ntrig2  = ntrig2 + (trig2 ? 1 : 0);
      nrpt    = nrpt + (rpt ? 1 : 0);
    end
    chk("norpt_press_count", npress2, 1);
    chk("norpt_rpt_count", nrpt2, 0);
    chk("norpt_trig_count", ntrig2, 1);
    chk("norpt_level", level2, 1);
    chk("main_rpt_count", nrpt, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
